// File: rtl/fcvt_f2i_pipe_if.sv
// Handshake bundle for fcvt_f2i_pipe: issue-side in_* and writeback-side out_* signals.
// out_flags exists only when FCVT_FLAGS_EN is defined.
interface fcvt_f2i_pipe_if #(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_num;
  logic [2:0]       in_rm;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] out_int;
  logic [TAG_W-1:0] out_tag;
`ifdef FCVT_FLAGS_EN
  logic [1:0]       out_flags;

  modport master (
    output in_valid, in_num, in_rm, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_int, out_tag, out_flags
  );
  modport slave (
    input  in_valid, in_num, in_rm, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_int, out_tag, out_flags
  );
`else
  modport master (
    output in_valid, in_num, in_rm, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_int, out_tag
  );
  modport slave (
    input  in_valid, in_num, in_rm, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_int, out_tag
  );
`endif
endinterface

// File: rtl/fcvt_f2i_pipe.sv
// Three-stage binary32 -> signed/unsigned INT_W-bit converter with rounding modes and saturation.
// Optional macro FCVT_FLAGS_EN adds the registered {NV, NX} flag output.
module fcvt_f2i_pipe #(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  fcvt_f2i_pipe_if.slave bus
);
  localparam int FW  = INT_W + 1;
  localparam int SHW = $clog2(FW + 1);
  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};

  logic r_s1Valid, r_s2Valid, r_s3Valid;
  logic w_s1Free, w_s2Free, w_s3Free;

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_s3Free     = !r_s3Valid || bus.out_ready;
  assign w_s2Free     = !r_s2Valid || w_s3Free;
  assign w_s1Free     = !r_s1Valid || w_s2Free;
  assign bus.in_ready = w_s1Free;

  logic [7:0]       w_inExp;
  logic [22:0]      w_inFrac;
  logic             w_inExpZero, w_inExpMax;
  logic             r_s1Sign, r_s1Tiny, r_s1Inf, r_s1Nan, r_s1Signed;
  logic [7:0]       r_s1Exp;
  logic [23:0]      r_s1Mant;
  logic [2:0]       r_s1Rm;
  logic [TAG_W-1:0] r_s1Tag;

  assign w_inExp     = bus.in_num[30:23];
  assign w_inFrac    = bus.in_num[22:0];
  assign w_inExpZero = (w_inExp == 8'h00);
  assign w_inExpMax  = (w_inExp == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid  <= 1'b0;
      r_s1Sign   <= 1'b0;
      r_s1Exp    <= '0;
      r_s1Mant   <= '0;
      r_s1Tiny   <= 1'b0;
      r_s1Inf    <= 1'b0;
      r_s1Nan    <= 1'b0;
      r_s1Rm     <= '0;
      r_s1Signed <= 1'b0;
      r_s1Tag    <= '0;
    end else if (w_s1Free) begin
      r_s1Valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1Sign   <= bus.in_num[31];
        r_s1Exp    <= w_inExp;
        r_s1Mant   <= {!w_inExpZero, w_inFrac};
        r_s1Tiny   <= w_inExpZero;
        r_s1Inf    <= w_inExpMax && (w_inFrac == 23'd0);
        r_s1Nan    <= w_inExpMax && (w_inFrac != 23'd0);
        r_s1Rm     <= bus.in_rm;
        r_s1Signed <= bus.in_signed;
        r_s1Tag    <= bus.in_tag;
      end
    end
  end

  // Mantissa is left-justified in INT_W integer bits plus a guard bit, then shifted right.
  logic [SHW-1:0]   w_sh;
  logic [FW-1:0]    w_m0, w_aligned;
  logic             w_lost, w_collapse, w_ovf;
  logic [INT_W-1:0] w_alInt;
  logic             w_alGuard, w_alSticky;

  assign w_m0       = {r_s1Mant, {(FW-24){1'b0}}};
  assign w_sh       = SHW'(9'(126 + INT_W) - {1'b0, r_s1Exp});
  assign w_aligned  = w_m0 >> w_sh;
  assign w_lost     = |(w_m0 & ~({FW{1'b1}} << w_sh));
  assign w_collapse = r_s1Tiny || (r_s1Exp < 8'd126);
  assign w_ovf      = r_s1Inf || ({1'b0, r_s1Exp} >= 9'(127 + INT_W));

  always_comb begin
    w_alInt    = w_aligned[FW-1:1];
    w_alGuard  = w_aligned[0];
    w_alSticky = w_lost;
    if (w_collapse) begin
      w_alInt    = '0;
      w_alGuard  = 1'b0;
      w_alSticky = |r_s1Mant;
    end
  end

  logic             r_s2Sign, r_s2Guard, r_s2Sticky, r_s2Ovf, r_s2Nan, r_s2Signed;
  logic [INT_W-1:0] r_s2Int;
  logic [2:0]       r_s2Rm;
  logic [TAG_W-1:0] r_s2Tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid  <= 1'b0;
      r_s2Sign   <= 1'b0;
      r_s2Int    <= '0;
      r_s2Guard  <= 1'b0;
      r_s2Sticky <= 1'b0;
      r_s2Ovf    <= 1'b0;
      r_s2Nan    <= 1'b0;
      r_s2Rm     <= '0;
      r_s2Signed <= 1'b0;
      r_s2Tag    <= '0;
    end else if (w_s2Free) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Sign   <= r_s1Sign;
        r_s2Int    <= w_alInt;
        r_s2Guard  <= w_alGuard;
        r_s2Sticky <= w_alSticky;
        r_s2Ovf    <= w_ovf;
        r_s2Nan    <= r_s1Nan;
        r_s2Rm     <= r_s1Rm;
        r_s2Signed <= r_s1Signed;
        r_s2Tag    <= r_s1Tag;
      end
    end
  end

  logic             w_inexact, w_inc, w_sat;
  logic [FW-1:0]    w_mag;
  logic [INT_W-1:0] w_res;

  assign w_inexact = r_s2Guard | r_s2Sticky;
  assign w_mag     = {1'b0, r_s2Int} + FW'(w_inc);

  // Rounding increment; encodings 5-7 fall through to truncation.
  always_comb begin
    w_inc = 1'b0;
    case (r_s2Rm)
      3'd0:    w_inc = r_s2Guard & (r_s2Sticky | r_s2Int[0]);
      3'd2:    w_inc = r_s2Sign & w_inexact;
      3'd3:    w_inc = !r_s2Sign & w_inexact;
      3'd4:    w_inc = r_s2Guard;
      default: w_inc = 1'b0;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    if (r_s2Nan) begin
      w_sat = 1'b1;
      w_res = r_s2Signed ? MAX_POS : '1;
    end else if (r_s2Ovf) begin
      w_sat = 1'b1;
      if (r_s2Sign) w_res = r_s2Signed ? MIN_NEG : '0;
      else          w_res = r_s2Signed ? MAX_POS : '1;
    end else if (r_s2Signed) begin
      if (!r_s2Sign) begin
        w_sat = (w_mag > {1'b0, MAX_POS});
        w_res = w_sat ? MAX_POS : w_mag[INT_W-1:0];
      end else begin
        w_sat = (w_mag > {1'b0, MIN_NEG});
        w_res = w_sat ? MIN_NEG : -w_mag[INT_W-1:0];
      end
    end else begin
      if (!r_s2Sign) begin
        w_sat = w_mag[INT_W];
        w_res = w_sat ? '1 : w_mag[INT_W-1:0];
      end else begin
        w_sat = |w_mag;
        w_res = '0;
      end
    end
  end

  logic [INT_W-1:0] r_outInt;
  logic [TAG_W-1:0] r_outTag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3Valid <= 1'b0;
      r_outInt  <= '0;
      r_outTag  <= '0;
    end else if (w_s3Free) begin
      r_s3Valid <= r_s2Valid;
      if (r_s2Valid) begin
        r_outInt <= w_res;
        r_outTag <= r_s2Tag;
      end
    end
  end

  assign bus.out_valid = r_s3Valid;
  assign bus.out_int   = r_outInt;
  assign bus.out_tag   = r_outTag;

`ifdef FCVT_FLAGS_EN
  // NV marks any saturated or special result; NX is suppressed whenever NV is raised.
  logic [1:0] r_outFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outFlags <= 2'b00;
    end else if (w_s3Free && r_s2Valid) begin
      r_outFlags <= {w_sat, w_inexact & !w_sat};
    end
  end

  assign bus.out_flags = r_outFlags;
`endif
endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// Scoreboard bench for fcvt_f2i_pipe: INT_W=32 and INT_W=64 instances, backpressure and mid-stream reset.
// Flag checks are compiled in only when FCVT_FLAGS_EN is defined.
module tb_fcvt_f2i_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fcvt_f2i_pipe_if #(.INT_W(32), .TAG_W(5)) b32 ();
  fcvt_f2i_pipe_if #(.INT_W(64), .TAG_W(5)) b64 ();

  fcvt_f2i_pipe #(.INT_W(32), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  fcvt_f2i_pipe #(.INT_W(64), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] val;
    logic [1:0]  flags;
  } expect_t;

  typedef struct packed {
    logic [31:0] num;
    logic [2:0]  rm;
    logic        sgn;
    logic [63:0] val;
    logic [1:0]  flags;
  } vec_t;

  expect_t sb32[$];
  expect_t sb64[$];
  int      nChecks   = 0;
  int      nPass     = 0;
  int      nAccepted = 0;
  bit      randReady = 1'b0;

  vec_t vecs32 [0:26] = '{
    '{32'h3FC00000, 3'd0, 1'b0, 64'd2,          2'b01},
    '{32'h3FC00000, 3'd1, 1'b0, 64'd1,          2'b01},
    '{32'h40200000, 3'd0, 1'b1, 64'd2,          2'b01},
    '{32'h40200000, 3'd4, 1'b1, 64'd3,          2'b01},
    '{32'hC0200000, 3'd2, 1'b1, 64'hFFFFFFFD,   2'b01},
    '{32'h4F000000, 3'd0, 1'b1, 64'h7FFFFFFF,   2'b10},
    '{32'hCF000000, 3'd0, 1'b1, 64'h80000000,   2'b00},
    '{32'h4F800000, 3'd0, 1'b0, 64'hFFFFFFFF,   2'b10},
    '{32'h7FC00000, 3'd0, 1'b1, 64'h7FFFFFFF,   2'b10},
    '{32'h7FC00000, 3'd0, 1'b0, 64'hFFFFFFFF,   2'b10},
    '{32'hFF800000, 3'd0, 1'b1, 64'h80000000,   2'b10},
    '{32'hFF800000, 3'd0, 1'b0, 64'h0,          2'b10},
    '{32'hBE99999A, 3'd1, 1'b0, 64'h0,          2'b01},
    '{32'hBE99999A, 3'd2, 1'b0, 64'h0,          2'b10},
    '{32'h00000001, 3'd3, 1'b0, 64'd1,          2'b01},
    '{32'h80000000, 3'd0, 1'b1, 64'h0,          2'b00},
    '{32'h3F800000, 3'd0, 1'b1, 64'd1,          2'b00},
    '{32'h7F800000, 3'd0, 1'b0, 64'hFFFFFFFF,   2'b10},
    '{32'h3FC00000, 3'd7, 1'b1, 64'd1,          2'b01},
    '{32'h3F000000, 3'd0, 1'b1, 64'd0,          2'b01},
    '{32'h3F000000, 3'd4, 1'b1, 64'd1,          2'b01},
    '{32'h40600000, 3'd0, 1'b1, 64'd4,          2'b01},
    '{32'hC0600000, 3'd3, 1'b1, 64'hFFFFFFFD,   2'b01},
    '{32'h4F7FFFFF, 3'd1, 1'b0, 64'hFFFFFF00,   2'b00},
    '{32'hCF000001, 3'd0, 1'b1, 64'h80000000,   2'b10},
    '{32'h5F000000, 3'd0, 1'b1, 64'h7FFFFFFF,   2'b10},
    '{32'hBFC00000, 3'd3, 1'b1, 64'hFFFFFFFF,   2'b01}
  };

  vec_t vecs64 [0:4] = '{
    '{32'h5F000000, 3'd0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 2'b10},
    '{32'h5F000000, 3'd0, 1'b0, 64'h8000000000000000, 2'b00},
    '{32'hDF000000, 3'd0, 1'b1, 64'h8000000000000000, 2'b00},
    '{32'h5F800000, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2'b10},
    '{32'h3FC00000, 3'd3, 1'b1, 64'd2,                2'b01}
  };

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Drives one operation, waits (bounded) for acceptance and records the expected result.
  task automatic applyStimulus(input bit use64, input logic [31:0] num, input logic [2:0] rm,
                               input logic sgn, input logic [4:0] tag,
                               input logic [63:0] expVal, input logic [1:0] expFlags);
    bit      gotReady;
    expect_t e;
    b32.in_num = num;  b32.in_rm = rm;  b32.in_signed = sgn;  b32.in_tag = tag;
    b64.in_num = num;  b64.in_rm = rm;  b64.in_signed = sgn;  b64.in_tag = tag;
    if (use64) b64.in_valid = 1'b1;
    else       b32.in_valid = 1'b1;
    gotReady = 1'b0;
    for (int i = 0; i < 200 && !gotReady; i++) begin
      @(negedge clk);
      gotReady = use64 ? b64.in_ready : b32.in_ready;
    end
    if (!gotReady) begin
      checkOutput("inReadyTimeout", {63'd0, (use64 ? b64.in_ready : b32.in_ready)}, 64'd1);
    end else begin
      e.tag = tag;  e.val = expVal;  e.flags = expFlags;
      if (use64) sb64.push_back(e);
      else       sb32.push_back(e);
      nAccepted++;
    end
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb32.size() != 0 || sb64.size() != 0); i++) @(negedge clk);
    checkOutput("sb32Drained", 64'(sb32.size()), 64'd0);
    checkOutput("sb64Drained", 64'(sb64.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      b32.out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin : mon32
    expect_t e;
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (sb32.size() == 0) begin
        checkOutput("spurious32", {59'd0, b32.out_tag}, 64'hFFFF);
      end else begin
        e = sb32.pop_front();
        checkOutput("int32", {32'd0, b32.out_int}, e.val);
        checkOutput("tag32", {59'd0, b32.out_tag}, {59'd0, e.tag});
`ifdef FCVT_FLAGS_EN
        checkOutput("flags32", {62'd0, b32.out_flags}, {62'd0, e.flags});
`endif
      end
    end
  end

  always @(negedge clk) begin : mon64
    expect_t e;
    if (rst_n && b64.out_valid && b64.out_ready) begin
      if (sb64.size() == 0) begin
        checkOutput("spurious64", {59'd0, b64.out_tag}, 64'hFFFF);
      end else begin
        e = sb64.pop_front();
        checkOutput("int64", b64.out_int, e.val);
        checkOutput("tag64", {59'd0, b64.out_tag}, {59'd0, e.tag});
`ifdef FCVT_FLAGS_EN
        checkOutput("flags64", {62'd0, b64.out_flags}, {62'd0, e.flags});
`endif
      end
    end
  end

  initial begin
    b32.in_valid = 1'b0;  b32.in_num = '0;  b32.in_rm = '0;  b32.in_signed = 1'b0;
    b32.in_tag = '0;      b32.out_ready = 1'b1;
    b64.in_valid = 1'b0;  b64.in_num = '0;  b64.in_rm = '0;  b64.in_signed = 1'b0;
    b64.in_tag = '0;      b64.out_ready = 1'b1;

    #1;
    checkOutput("rstOutValid", {63'd0, b32.out_valid}, 64'd0);
    checkOutput("rstOutInt", {32'd0, b32.out_int}, 64'd0);
    checkOutput("rstOutTag", {59'd0, b32.out_tag}, 64'd0);
`ifdef FCVT_FLAGS_EN
    checkOutput("rstOutFlags", {62'd0, b32.out_flags}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstInReady", {63'd0, b32.in_ready}, 64'd1);

    // Vector table with random consumer stalls on the 32-bit instance.
    randReady = 1'b1;
    for (int i = 0; i < 27; i++)
      applyStimulus(1'b0, vecs32[i].num, vecs32[i].rm, vecs32[i].sgn, 5'(i),
                    vecs32[i].val, vecs32[i].flags);
    @(negedge clk);
    randReady = 1'b0;
    @(posedge clk);
    #2;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, vecs64[i].num, vecs64[i].rm, vecs64[i].sgn, 5'(i + 10),
                    vecs64[i].val, vecs64[i].flags);
    drain();

    // Backpressure: six back-to-back operations against a stalled consumer.
    @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    nAccepted = 0;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          applyStimulus(1'b0, (t == 1) ? 32'h3F800000 : (t == 2) ? 32'h40000000 :
                              (t == 3) ? 32'h40400000 : (t == 4) ? 32'h40800000 :
                              (t == 5) ? 32'h40A00000 : 32'h40C00000,
                        3'd0, 1'b1, 5'(t), 64'(t), 2'b00);
      end
      begin
        for (int c = 1; c <= 8; c++) begin
          @(negedge clk);
          if (c >= 4) begin
            checkOutput("bpHoldValid", {63'd0, b32.out_valid}, 64'd1);
            checkOutput("bpHoldTag", {59'd0, b32.out_tag}, 64'd1);
            checkOutput("bpHoldInt", {32'd0, b32.out_int}, 64'd1);
          end
        end
        checkOutput("bpAccepted", 64'(nAccepted), 64'd3);
        checkOutput("bpInReadyLow", {63'd0, b32.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        b32.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight; they must be discarded.
    @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    applyStimulus(1'b0, 32'h40000000, 3'd0, 1'b1, 5'd20, 64'd2, 2'b00);
    applyStimulus(1'b0, 32'h40400000, 3'd0, 1'b1, 5'd21, 64'd3, 2'b00);
    applyStimulus(1'b0, 32'h40800000, 3'd0, 1'b1, 5'd22, 64'd4, 2'b00);
    @(posedge clk);
    #2;
    checkOutput("preRstValid", {63'd0, b32.out_valid}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", {63'd0, b32.out_valid}, 64'd0);
    checkOutput("asyncRstInt", {32'd0, b32.out_int}, 64'd0);
    checkOutput("asyncRstTag", {59'd0, b32.out_tag}, 64'd0);
`ifdef FCVT_FLAGS_EN
    checkOutput("asyncRstFlags", {62'd0, b32.out_flags}, 64'd0);
`endif
    sb32.delete();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postRstInReady", {63'd0, b32.in_ready}, 64'd1);
    checkOutput("postRstNoStale", {63'd0, b32.out_valid}, 64'd0);
    b32.out_ready = 1'b1;
    applyStimulus(1'b0, 32'h3F800000, 3'd0, 1'b1, 5'd9, 64'd1, 2'b00);
    @(negedge clk);
    checkOutput("latencyS1", {63'd0, b32.out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("latencyS2", {63'd0, b32.out_valid}, 64'd0);
    @(negedge clk);
    checkOutput("latencyS3", {63'd0, b32.out_valid}, 64'd1);
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
